// File: rtl/pc_trace_buffer.sv
// PC trace recorder: logs PC changes with timestamps into a circular buffer, flags halt, freezes on trigger.
// Optional feature macro: PC_TRACE_DISPLAY_EN (prints each write and the halt event).
module pc_trace_buffer #(
  parameter int unsigned PC_W        = 64,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned CYC_W       = 32,
  parameter int unsigned STALL_LIMIT = 8,
  parameter int unsigned POST_TRIG   = 4,
  localparam int unsigned IDX_W      = $clog2(DEPTH),
  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             pc_valid,
  input  logic             clear,
  input  logic             trig_en,
  input  logic [PC_W-1:0]  trig_pc,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [PC_W-1:0]  rd_pc,
  output logic [CYC_W-1:0] rd_cycle,
  output logic             rd_err,
  output logic [CNT_W-1:0] count,
  output logic             wrapped,
  output logic             halted,
  output logic             frozen,
  output logic [CYC_W-1:0] cycle_count
);

  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
  localparam int unsigned PW = $clog2(POST_TRIG + 2);

  typedef enum logic [1:0] {ARMED, POST, FROZEN} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     post_q, post_d;
  logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PC_W-1:0]   last_pc_q, last_pc_d;
  logic              first_q, first_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic [CNT_W-1:0]  count_d;
  logic              wrapped_d, halted_d, frozen_d;

  logic [PC_W-1:0]   mem_pc  [DEPTH];
  logic [CYC_W-1:0]  mem_cyc [DEPTH];

  logic              wr_c, match_c, wr_en_c, rd_bad_c;
  logic [IDX_W-1:0]  rd_addr_c;

  assign wr_c      = pc_valid && (state_q != FROZEN) && (first_q || (pc_in != last_pc_q));
  assign match_c   = pc_valid && !first_q && (pc_in == last_pc_q);
  assign wr_en_c   = wr_c && !clear;
  assign rd_addr_c = wr_ptr_q - IDX_W'(count) + rd_idx;
  assign rd_bad_c  = CNT_W'(rd_idx) >= count;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARMED;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  // Next-state logic: trigger arms the post-trigger window, its last write freezes
  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (clear) begin
      state_d = ARMED;
    end else if (wr_c) begin
      case (state_q)
        ARMED: begin
          if (trig_en && (pc_in == trig_pc)) begin
            if (POST_TRIG == 0) begin
              state_d = FROZEN;
            end else begin
              state_d = POST;
              post_d  = PW'(POST_TRIG);
            end
          end
        end
        POST: begin
          post_d = post_q - PW'(1);
          if (post_q == PW'(1)) state_d = FROZEN;
        end
        default: ;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    count_d   = count;
    wr_ptr_d  = wr_ptr_q;
    last_pc_d = last_pc_q;
    first_d   = first_q;
    stall_d   = stall_q;
    wrapped_d = wrapped;
    halted_d  = halted;
    if (clear) begin
      count_d   = '0;
      wr_ptr_d  = '0;
      first_d   = 1'b1;
      stall_d   = '0;
      wrapped_d = 1'b0;
      halted_d  = 1'b0;
    end else begin
      if (wr_c) begin
        wr_ptr_d  = wr_ptr_q + IDX_W'(1);
        last_pc_d = pc_in;
        first_d   = 1'b0;
        stall_d   = '0;
        if (count == CNT_W'(DEPTH)) wrapped_d = 1'b1;
        else                        count_d   = count + CNT_W'(1);
      end else if (match_c && (stall_q != SW'(STALL_LIMIT))) begin
        stall_d = stall_q + SW'(1);
      end
      if (stall_d == SW'(STALL_LIMIT)) halted_d = 1'b1;
    end
    frozen_d = (state_d == FROZEN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count       <= '0;
      wr_ptr_q    <= '0;
      last_pc_q   <= '0;
      first_q     <= 1'b1;
      stall_q     <= '0;
      wrapped     <= 1'b0;
      halted      <= 1'b0;
      frozen      <= 1'b0;
      cycle_count <= '0;
      rd_pc       <= '0;
      rd_cycle    <= '0;
      rd_err      <= 1'b0;
    end else begin
      count       <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      last_pc_q   <= last_pc_d;
      first_q     <= first_d;
      stall_q     <= stall_d;
      wrapped     <= wrapped_d;
      halted      <= halted_d;
      frozen      <= frozen_d;
      cycle_count <= cycle_count + CYC_W'(1);
      rd_err      <= rd_bad_c;
      rd_pc       <= rd_bad_c ? '0 : mem_pc[rd_addr_c];
      rd_cycle    <= rd_bad_c ? '0 : mem_cyc[rd_addr_c];
    end
  end

  // Storage is masked by count, so it carries no reset
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem_pc[wr_ptr_q]  <= pc_in;
      mem_cyc[wr_ptr_q] <= cycle_count;
    end
  end

`ifdef PC_TRACE_DISPLAY_EN
  always_ff @(posedge clk) begin
    if (rst && wr_en_c) $display("%0t PC=%h cyc=%0d", $time, pc_in, cycle_count);
    if (rst && halted_d && !halted) $display("HALT PC=%h", last_pc_q);
  end
`else
  // Default build emits no trace output
`endif

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Directed self-checking bench for pc_trace_buffer (DEPTH=4, STALL_LIMIT=3, POST_TRIG=1).
module tb_pc_trace_buffer;
  localparam int unsigned PC_W = 32;
  localparam int unsigned CYC_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [PC_W-1:0]  pc_in;
  logic             pc_valid, clear, trig_en;
  logic [PC_W-1:0]  trig_pc;
  logic [1:0]       rd_idx;
  logic [PC_W-1:0]  rd_pc;
  logic [CYC_W-1:0] rd_cycle;
  logic             rd_err;
  logic [2:0]       count;
  logic             wrapped, halted, frozen;
  logic [CYC_W-1:0] cycle_count;

  int errors = 0;
  int checks = 0;

  pc_trace_buffer #(.PC_W(PC_W), .DEPTH(4), .CYC_W(CYC_W), .STALL_LIMIT(3), .POST_TRIG(1)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .clear(clear),
    .trig_en(trig_en), .trig_pc(trig_pc), .rd_idx(rd_idx), .rd_pc(rd_pc),
    .rd_cycle(rd_cycle), .rd_err(rd_err), .count(count), .wrapped(wrapped),
    .halted(halted), .frozen(frozen), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PC_W-1:0] pc);
    pc_in = pc;
    pc_valid = 1'b1;
    cycle();
  endtask

  task automatic do_reset();
    pc_valid = 1'b0; clear = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_idx = '0; pc_in = '0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc_in = '0; pc_valid = 1'b0; clear = 1'b0; trig_en = 1'b0; trig_pc = '0; rd_idx = '0;
    #2;
    checks++; if ({rd_pc, rd_cycle, rd_err, count, wrapped, halted, frozen, cycle_count} !== '0) begin
      errors++; $display("FAIL reset_outputs count=%0d cyc=%0d frozen=%b exp all zero", count, cycle_count, frozen); end
    cycle();
    rst = 1'b1;
    push(32'd100); push(32'd104); push(32'd108);
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL prereset_count got=%0d exp=3", count); end
    checks++; if (cycle_count !== 16'd3) begin errors++; $display("FAIL prereset_cyc got=%0d exp=3", cycle_count); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if ({count, wrapped, halted, frozen, cycle_count, rd_pc} !== '0) begin
      errors++; $display("FAIL midrun_reset count=%0d cyc=%0d rd_pc=%0h exp all zero", count, cycle_count, rd_pc); end
    pc_in = 32'd112;
    cycle();
    pc_in = 32'd116;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL held_reset_count got=%0d exp=0", count); end
    pc_valid = 1'b0;
    rst = 1'b1;
    checks++; if (cycle_count !== 16'd0) begin errors++; $display("FAIL release_cyc got=%0d exp=0", cycle_count); end
    cycle();
    checks++; if (cycle_count !== 16'd1 || count !== 3'd0) begin
      errors++; $display("FAIL restart cyc=%0d count=%0d exp cyc=1 count=0", cycle_count, count); end
  endtask

  task automatic test_wrap();
    do_reset();
    push(32'd0); push(32'd4); push(32'd8); push(32'd12); push(32'd16); push(32'd20);
    pc_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL wrap_count got=%0d exp=4", count); end
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_flag got=%b exp=1", wrapped); end
    rd_idx = 2'd0;
    cycle();
    checks++; if (rd_pc !== 32'd8 || rd_cycle !== 16'd2 || rd_err !== 1'b0) begin
      errors++; $display("FAIL wrap_rd0 pc=%0d cyc=%0d err=%b exp pc=8 cyc=2 err=0", rd_pc, rd_cycle, rd_err); end
    rd_idx = 2'd3;
    cycle();
    checks++; if (rd_pc !== 32'd20 || rd_cycle !== 16'd5) begin
      errors++; $display("FAIL wrap_rd3 pc=%0d cyc=%0d exp pc=20 cyc=5", rd_pc, rd_cycle); end
  endtask

  task automatic test_halt();
    do_reset();
    push(32'd0); push(32'd4); push(32'd4); push(32'd4);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early got=%b exp=0", halted); end
    push(32'd4);
    checks++; if (halted !== 1'b1 || count !== 3'd2) begin
      errors++; $display("FAIL halt_set halted=%b count=%0d exp halted=1 count=2", halted, count); end
    push(32'd8);
    pc_valid = 1'b0;
    checks++; if (halted !== 1'b1 || count !== 3'd3) begin
      errors++; $display("FAIL halt_sticky halted=%b count=%0d exp halted=1 count=3", halted, count); end
    rd_idx = 2'd2;
    cycle();
    checks++; if (rd_pc !== 32'd8) begin errors++; $display("FAIL halt_rd2 got=%0d exp=8", rd_pc); end
  endtask

  task automatic test_trigger();
    do_reset();
    trig_en = 1'b1; trig_pc = 32'd8;
    push(32'd0); push(32'd4); push(32'd8);
    checks++; if (frozen !== 1'b0) begin errors++; $display("FAIL trig_post_frozen got=%b exp=0", frozen); end
    push(32'd12);
    checks++; if (frozen !== 1'b1) begin errors++; $display("FAIL trig_frozen got=%b exp=1", frozen); end
    push(32'd16);
    pc_valid = 1'b0;
    checks++; if (count !== 3'd4 || wrapped !== 1'b0 || frozen !== 1'b1) begin
      errors++; $display("FAIL trig_final count=%0d wrapped=%b frozen=%b exp 4 0 1", count, wrapped, frozen); end
    rd_idx = 2'd3;
    cycle();
    checks++; if (rd_pc !== 32'd12) begin errors++; $display("FAIL trig_rd3 got=%0d exp=12", rd_pc); end
  endtask

  task automatic test_clear();
    trig_en = 1'b0;
    pc_in = 32'd24; pc_valid = 1'b1; clear = 1'b1;
    cycle();
    clear = 1'b0; pc_valid = 1'b0;
    checks++; if (count !== 3'd0 || frozen !== 1'b0 || wrapped !== 1'b0) begin
      errors++; $display("FAIL clear_state count=%0d frozen=%b wrapped=%b exp 0 0 0", count, frozen, wrapped); end
    push(32'd28);
    pc_valid = 1'b0;
    rd_idx = 2'd0;
    cycle();
    checks++; if (rd_pc !== 32'd28 || count !== 3'd1 || rd_err !== 1'b0) begin
      errors++; $display("FAIL clear_rd0 pc=%0d count=%0d err=%b exp pc=28 count=1 err=0", rd_pc, count, rd_err); end
  endtask

  task automatic test_invalid();
    do_reset();
    push(32'd40);
    rd_idx = 2'd2;
    push(32'd40);
    checks++; if (rd_err !== 1'b1 || rd_pc !== 32'd0 || rd_cycle !== 16'd0) begin
      errors++; $display("FAIL rd_err err=%b pc=%0d cyc=%0d exp err=1 pc=0 cyc=0", rd_err, rd_pc, rd_cycle); end
    push(32'd40);
    pc_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc_in = 32'd44 + 32'(4 * i);
      cycle();
    end
    checks++; if (count !== 3'd1 || halted !== 1'b0) begin
      errors++; $display("FAIL invalid_hold count=%0d halted=%b exp count=1 halted=0", count, halted); end
    push(32'd40);
    pc_valid = 1'b0;
    checks++; if (halted !== 1'b1 || count !== 3'd1) begin
      errors++; $display("FAIL stall_resume halted=%b count=%0d exp halted=1 count=1", halted, count); end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_halt();
    test_trigger();
    test_clear();
    test_invalid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
